// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: slave indices, address map regions and decoder FSM encoding.
// Used by wb_addr_match, wb_bus_decoder and the SoC top.
package soc_bus_pkg;

   localparam int NUM_SLV     = 3;
   localparam int SLV_BOOTROM = 0;
   localparam int SLV_RAM     = 1;
   localparam int SLV_UART    = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } bus_state_t;

   // An index outside the map returns a base that can never match a masked address.
   function automatic logic [31:0] region_base(input int k);
      case (k)
         SLV_BOOTROM: return 32'hb000_0000;
         SLV_RAM:     return 32'hb000_8000;
         SLV_UART:    return 32'hc000_0000;
         default:     return 32'hffff_ffff;
      endcase
   endfunction

   function automatic logic [31:0] region_mask(input int k);
      case (k)
         SLV_BOOTROM: return 32'hffff_8000;
         SLV_RAM:     return 32'hffff_8000;
         SLV_UART:    return 32'hffff_0000;
         default:     return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Combinational address decode: one-hot hit vector over the slave regions plus a mapped flag.
module wb_addr_match
   import soc_bus_pkg::*;
#(
   parameter int NSLAVES = NUM_SLV
) (
   input  logic [31:0]        addr,
   output logic [NSLAVES-1:0] hit,
   output logic               mapped
);

   generate
      for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_region
         assign hit[gi] = ((addr & region_mask(gi)) == region_base(gi));
      end
   endgenerate

   assign mapped = |hit;

endmodule

// File: rtl/wb_bus_decoder.sv
// Single-master pipelined Wishbone decoder: per-slave strobes, selected-slave ack/data return,
// bus error on unmapped access. Optional hung-slave timeout via WB_DECODER_TIMEOUT_EN.
module wb_bus_decoder
   import soc_bus_pkg::*;
#(
   parameter int NSLAVES = NUM_SLV,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wb_cyc,
   input  logic                  i_wb_stb,
   input  logic [31:0]           i_wb_addr,
   output logic [DW-1:0]         o_wb_data,
   output logic                  o_wb_ack,
   output logic                  o_wb_stl,
   output logic                  o_wb_err,
   output logic                  o_exception,
   output logic [NSLAVES-1:0]    o_s_stb,
   input  logic [NSLAVES-1:0]    i_s_ack,
   input  logic [NSLAVES-1:0]    i_s_stl,
   input  logic [NSLAVES*DW-1:0] i_s_data
);

   localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

   bus_state_t          state_reg, state_next;
   logic [SW-1:0]       sel_q, sel_next;
   logic [NSLAVES-1:0]  hit;
   logic                mapped;
   logic [SW-1:0]       hit_idx;
   logic                wait_expired;
   logic                req;
   logic [DW-1:0]       s_data_arr [NSLAVES];

   wb_addr_match #(.NSLAVES(NSLAVES)) u_match (
      .addr   (i_wb_addr),
      .hit    (hit),
      .mapped (mapped)
   );

   generate
      for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_data
         assign s_data_arr[gi] = i_s_data[gi*DW +: DW];
      end
   endgenerate

   assign req = i_wb_cyc & i_wb_stb;

   always_comb begin
      hit_idx = '0;
      for (int k = 0; k < NSLAVES; k++) begin
         if (hit[k]) hit_idx = SW'(k);
      end
   end

`ifdef WB_DECODER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt_reg;

   // Held at zero outside WAIT so every WAIT entry starts a fresh count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                     wait_cnt_reg <= '0;
      else if (state_reg != ST_WAIT) wait_cnt_reg <= '0;
      else                           wait_cnt_reg <= wait_cnt_reg + 1'b1;
   end

   assign wait_expired = (wait_cnt_reg == CW'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign wait_expired   = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         sel_q     <= '0;
      end else begin
         state_reg <= state_next;
         sel_q     <= sel_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      sel_next    = sel_q;
      o_s_stb     = '0;
      o_wb_ack    = 1'b0;
      o_wb_err    = 1'b0;
      o_exception = 1'b0;
      o_wb_stl    = 1'b0;
      o_wb_data   = '0;
      case (state_reg)
         ST_IDLE: begin
            if (req) begin
               o_s_stb  = hit;
               o_wb_stl = mapped & (|(hit & i_s_stl));
               if (!o_wb_stl) begin
                  if (mapped) begin
                     sel_next   = hit_idx;
                     state_next = ST_WAIT;
                  end else begin
                     state_next = ST_ERR;
                  end
               end
            end
         end
         ST_WAIT: begin
            o_wb_stl = 1'b1;
            // A dropped cycle aborts the access; the slave's ack is never forwarded.
            if (!i_wb_cyc) begin
               state_next = ST_IDLE;
            end else if (i_s_ack[sel_q]) begin
               o_wb_ack   = 1'b1;
               o_wb_data  = s_data_arr[sel_q];
               state_next = ST_IDLE;
            end else if (wait_expired) begin
               state_next = ST_ERR;
            end
         end
         ST_ERR: begin
            o_wb_err    = 1'b1;
            o_exception = 1'b1;
            o_wb_stl    = 1'b1;
            state_next  = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      // Outputs follow reset immediately, not only after the next clock edge.
      if (reset) begin
         o_s_stb     = '0;
         o_wb_ack    = 1'b0;
         o_wb_err    = 1'b0;
         o_exception = 1'b0;
         o_wb_stl    = 1'b0;
         o_wb_data   = '0;
      end
   end

endmodule
